// File: rtl/rvsteel_reset_pkg.sv
// -----------------------------------------------------------------------------
// rvsteel_reset_pkg
// Shared definitions for the rvsteel reset controller:
//   - FSM state encodings (HOLD / RUN)
//   - reset_cause codes reported to software
//   - debounce length computation and the saturating reset counter helper
// -----------------------------------------------------------------------------
package rvsteel_reset_pkg;

    // FSM states: the SoC is held in reset in HOLD and released in RUN.
    localparam logic [0:0] STATE_HOLD = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    // Cause of the last reset; 2'b11 is never produced.
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_LOCAL  = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;

    // Number of stable cycles needed before a button level change is accepted.
    // Never returns less than one so the debounce counter always has a target.
    function automatic int unsigned debounce_cycles(
        input int unsigned clock_frequency,
        input int unsigned debounce_time_us
    );
        int unsigned cycles;
        cycles = (clock_frequency / 32'd1000000) * debounce_time_us;
        return (cycles == 32'd0) ? 32'd1 : cycles;
    endfunction

    // Increment an 8-bit event counter, sticking at its maximum.
    function automatic logic [7:0] saturating_increment(input logic [7:0] value);
        return (value == 8'd255) ? 8'd255 : (value + 8'd1);
    endfunction

endpackage

// File: rtl/rvsteel_button_debouncer.sv
// -----------------------------------------------------------------------------
// rvsteel_button_debouncer
// Brings the raw push-button into the clock domain, normalises its polarity and
// only accepts a level change once it has been stable for DEBOUNCE_CYCLES.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-low local reset
//   button_in    in   raw asynchronous button (bounces)
//   button_level out  debounced button, 1 = pressed (registered)
//   press_event  out  one-cycle pulse on the 0->1 edge of button_level (registered)
// -----------------------------------------------------------------------------
module rvsteel_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES     = 32'd1,
    parameter logic        BUTTON_ACTIVE_LEVEL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_level,
    output logic press_event
);

    localparam int unsigned COUNT_WIDTH =
        (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = COUNT_WIDTH'(1'b0);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1'b1);
    localparam logic                   BUTTON_IDLE_LEVEL = ~BUTTON_ACTIVE_LEVEL;

    logic                   sync_0_r;
    logic                   sync_1_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   button_level_r;
    logic                   press_event_r;
    logic                   pressed_s;
    logic                   differs_s;
    logic                   toggle_s;

    // Two-flop synchroniser; reset parks both flops at the idle level so no
    // phantom press is seen when reset is released.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_0_r <= BUTTON_IDLE_LEVEL;
            sync_1_r <= BUTTON_IDLE_LEVEL;
        end else begin
            sync_0_r <= button_in;
            sync_1_r <= sync_0_r;
        end
    end

    // Polarity normalisation and debounce decision.
    always_comb begin
        pressed_s = (sync_1_r == BUTTON_ACTIVE_LEVEL);
        differs_s = (pressed_s != button_level_r);
        toggle_s  = differs_s && (count_r == COUNT_LAST);
    end

    // Stability counter: any agreement (a bounce back) restarts the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= COUNT_ZERO;
        end else if (!differs_s || toggle_s) begin
            count_r <= COUNT_ZERO;
        end else begin
            count_r <= count_r + COUNT_ONE;
        end
    end

    // Accepted level and its rising-edge pulse, produced on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            button_level_r <= 1'b0;
            press_event_r  <= 1'b0;
        end else if (toggle_s) begin
            button_level_r <= ~button_level_r;
            press_event_r  <= ~button_level_r;
        end else begin
            button_level_r <= button_level_r;
            press_event_r  <= 1'b0;
        end
    end

    assign button_level = button_level_r;
    assign press_event  = press_event_r;

endmodule

// File: rtl/rvsteel_reset_controller.sv
// -----------------------------------------------------------------------------
// rvsteel_reset_controller
// Merges the local system reset and the debounced push-button into one clean,
// stretched reset for the rvsteel_soc, and reports what caused the last reset.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-low local reset (highest priority)
//   button_in    in   raw asynchronous push-button
//   soc_reset    out  active-high reset to the SoC, registered
//   reset_cause  out  00 none, 01 local reset, 10 button
//   reset_count  out  button-initiated resets, saturating at 255
//   button_level out  debounced button status, 1 = pressed
// -----------------------------------------------------------------------------
module rvsteel_reset_controller
    import rvsteel_reset_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY     = 32'd27000000,
    parameter int unsigned DEBOUNCE_TIME_US    = 32'd10000,
    parameter int unsigned HOLD_CYCLES         = 32'd1024,
    parameter logic        BUTTON_ACTIVE_LEVEL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_in,
    output logic       soc_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count,
    output logic       button_level
);

    localparam int unsigned DEBOUNCE_CYCLES = debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
    localparam int unsigned HOLD_WIDTH =
        (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 32'd1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 32'd1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = HOLD_WIDTH'(1'b0);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1'b1);

    logic [0:0]            state_r;
    logic [0:0]            state_next_s;
    logic [HOLD_WIDTH-1:0] hold_count_r;
    logic [HOLD_WIDTH-1:0] hold_count_next_s;
    logic [1:0]            cause_r;
    logic [1:0]            cause_next_s;
    logic [7:0]            count_r;
    logic [7:0]            count_next_s;
    logic                  soc_reset_r;
    logic                  button_level_s;
    logic                  press_event_s;

    rvsteel_button_debouncer #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .BUTTON_ACTIVE_LEVEL(BUTTON_ACTIVE_LEVEL)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .button_in   (button_in),
        .button_level(button_level_s),
        .press_event (press_event_s)
    );

    // Next-state logic. A press while already holding is ignored; the hold
    // is only left once the minimum time has elapsed and the button is up.
    always_comb begin
        state_next_s      = state_r;
        hold_count_next_s = hold_count_r;
        cause_next_s      = cause_r;
        count_next_s      = count_r;
        case (state_r)
            STATE_HOLD: begin
                if (hold_count_r == HOLD_LAST) begin
                    if (!button_level_s) begin
                        state_next_s = STATE_RUN;
                    end else begin
                        state_next_s = STATE_HOLD;
                    end
                end else begin
                    hold_count_next_s = hold_count_r + HOLD_ONE;
                end
            end
            STATE_RUN: begin
                if (press_event_s) begin
                    state_next_s      = STATE_HOLD;
                    hold_count_next_s = HOLD_ZERO;
                    cause_next_s      = CAUSE_BUTTON;
                    count_next_s      = saturating_increment(count_r);
                end else begin
                    state_next_s = STATE_RUN;
                end
            end
            default: begin
                state_next_s      = STATE_HOLD;
                hold_count_next_s = HOLD_ZERO;
            end
        endcase
    end

    // State registers; local reset overrides any event in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= STATE_HOLD;
            hold_count_r <= HOLD_ZERO;
            cause_r      <= CAUSE_LOCAL;
            count_r      <= 8'd0;
            soc_reset_r  <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            hold_count_r <= hold_count_next_s;
            cause_r      <= cause_next_s;
            count_r      <= count_next_s;
            soc_reset_r  <= (state_next_s == STATE_HOLD);
        end
    end

    assign soc_reset    = soc_reset_r;
    assign reset_cause  = cause_r;
    assign reset_count  = count_r;
    assign button_level = button_level_s;

endmodule

// File: doc/rvsteel_reset_controller.md
Name: rvsteel_reset_controller

Overview:
- Conditions the board's raw push-button and the local system reset into one clean, stretched reset for the rvsteel_soc instance in each board top level.
- Instantiated directly upstream of the SoC; its soc_reset output drives the SoC reset input.
- Synchronises and debounces the button, holds the SoC in reset for a fixed minimum time, and reports what caused the last reset.

Parameters:
- CLOCK_FREQUENCY, 27000000: clock frequency in Hz. Must be a multiple of 1000000.
- DEBOUNCE_TIME_US, 10000: time the button must be stable before a level change is accepted, in microseconds. DEBOUNCE_CYCLES = (CLOCK_FREQUENCY/1000000)*DEBOUNCE_TIME_US, minimum 1.
- HOLD_CYCLES, 1024: minimum number of cycles soc_reset stays asserted. Must be at least 2.
- BUTTON_ACTIVE_LEVEL, 1: button_in level that means "pressed".

Ports:
- clock  input  1  system clock
- reset  input  1  local reset; synchronous, active-low
- button_in  input  1  raw, asynchronous push-button; bounces
- soc_reset  output  1  reset to the SoC; active-high, synchronous to clock
- reset_cause  output  2  cause of the last reset: 00 none, 01 local reset, 10 button; 11 is unused
- reset_count  output  8  number of button-initiated resets; saturates at 255
- button_level  output  1  debounced button, 1 = pressed (status only)

Behaviour:
- Local reset (reset=0 sampled on a clock edge):
  - state=HOLD, hold counter=0, soc_reset=1, reset_cause=01, reset_count=0, button_level=0.
  - Both synchroniser flops are loaded with the inactive level; the debounce counter is cleared.
  - Reset applied mid-HOLD or mid-debounce aborts everything and restarts from these values.
- Synchroniser:
  - Two flops on button_in, then polarity normalised so that 1 = pressed. Latency is 2 edges.
- Debouncer:
  - The counter increments on each edge where the synchronised level differs from button_level.
  - It clears on any edge where the two are equal, so a bounce restarts the count.
  - button_level toggles on the edge where the counter reaches DEBOUNCE_CYCLES-1, and the counter clears on that same edge.
  - Net effect: a clean press shows on button_level DEBOUNCE_CYCLES edges after the synchroniser output changes.
  - press_event is a 1-cycle internal pulse on the 0->1 transition of button_level.
- FSM, two states:
  - HOLD:
    - soc_reset=1; the hold counter increments and saturates at HOLD_CYCLES-1.
    - Exit to RUN on the edge after the counter is at HOLD_CYCLES-1 and button_level=0.
    - While the button is still held, stay in HOLD indefinitely: the SoC is released only after the button is released.
  - RUN:
    - soc_reset=0.
    - On press_event: go to HOLD, clear the hold counter, set reset_cause=10, increment reset_count (no change at 255).
- Timing:
  - soc_reset rises on the edge after press_event. Total button-to-reset latency = 2 + DEBOUNCE_CYCLES + 1 edges.
  - After local reset is released with the button idle, soc_reset stays 1 for exactly HOLD_CYCLES cycles, then falls.
  - A press_event while in HOLD is ignored: no count increment, no counter restart.
- Simultaneous events: reset=0 has priority over every other event in the same cycle.
- All outputs are registered. There is no combinational path from button_in to any output.

Decomposition:
- Shared package/header rvsteel_reset_pkg holds:
  - state encodings (HOLD=1'b0, RUN=1'b1);
  - reset_cause codes (CAUSE_NONE=2'b00, CAUSE_LOCAL=2'b01, CAUSE_BUTTON=2'b10);
  - the DEBOUNCE_CYCLES computation function.
- One sub-module, rvsteel_button_debouncer:
  - contains the synchroniser, polarity normalisation and debounce counter;
  - outputs button_level and press_event.
- The FSM, hold counter, reset_cause and reset_count stay in the top level.

Test Plan (CLOCK_FREQUENCY=1000000, DEBOUNCE_TIME_US=8, HOLD_CYCLES=16, BUTTON_ACTIVE_LEVEL=1 unless stated):
- Local reset: reset=0 for 3 cycles, then 1, button idle -> soc_reset=1 for exactly 16 edges after release, then 0; reset_cause=01; reset_count=0.
- Clean press: button_in rises at edge 0 and is held 40 cycles -> button_level=1 at edge 10; soc_reset=1 from edge 11; reset_cause=10; reset_count=1; soc_reset falls 1 edge after hold complete and button_level=0 (button release at edge 40, button_level=0 at edge 50).
- Bounce rejection: button_in pulses of 7, 3 and 5 cycles separated by 1-cycle gaps -> soc_reset never asserts; reset_count stays 0.
- Short press: 9-cycle press -> exactly one reset of 16 cycles; reset_count=1.
- Saturation and inversion: 256 clean presses -> reset_count=255. With BUTTON_ACTIVE_LEVEL=0 and button_in driven low as the press -> same behaviour.
- Mid-operation reset: reset=0 at edge 5 of a HOLD entered by button -> reset_count=0, reset_cause=01, full 16-cycle hold restarts from release.
